// File: rtl/note_detect_pkg.sv
// note_detect_pkg: shared types and band table
// for the averaging note detector.
package note_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam int NUM_NOTES = 8;
  localparam int BAND_W = 32;
  localparam int STABLE_W = 4;

  // Element 0 is the leftmost entry.
  // The note code equals the band index:
  // 0 Sa, 1 Re, 2 Ga, 3 Ma, 4 Pa,
  // 5 Dha, 6 Ni, 7 HighSa.
  typedef logic [0:NUM_NOTES-1][BAND_W-1:0]
    band_arr_t;

  localparam band_arr_t BAND_LO = {
    32'd190000, 32'd170000,
    32'd150000, 32'd135000,
    32'd125000, 32'd110000,
    32'd95000,  32'd93000
  };

  localparam band_arr_t BAND_HI = {
    32'd210000, 32'd190000,
    32'd170000, 32'd150000,
    32'd135000, 32'd125000,
    32'd110000, 32'd95000
  };

endpackage

// File: rtl/note_band_lookup.sv
// note_band_lookup: one-cycle registered band
// match of a window average to a note code.
module note_band_lookup
  import note_detect_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int NOTE_W = 3,
  parameter band_arr_t LO_TABLE = BAND_LO,
  parameter band_arr_t HI_TABLE = BAND_HI
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe,
  input  logic [CNT_W-1:0]  avg,
  output logic              valid,
  output logic              match,
  output logic [NOTE_W-1:0] code
);

  logic [BAND_W-1:0] avg_w;
  logic              hit;
  logic [NOTE_W-1:0] hit_code;

  assign avg_w = BAND_W'(avg);

  // Scan high to low so the lowest matching
  // band index is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_code = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (avg_w >= LO_TABLE[i] &&
          avg_w < HI_TABLE[i]) begin
        hit = 1'b1;
        hit_code = NOTE_W'(i);
      end
    end
  end

  // Register the lookup result with its strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      match <= 1'b0;
      code  <= '0;
    end else begin
      valid <= strobe;
      if (strobe) begin
        match <= hit;
        code  <= hit_code;
      end
    end
  end

endmodule

// File: rtl/note_detector_avg.sv
// note_detector_avg: averages tone periods over a
// window, classifies, and filters for stability.
module note_detector_avg
  import note_detect_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int NOTE_W = 3,
  parameter int AVG_LOG2 = 2,
  parameter int STABLE_N = 2,
  parameter int TIMEOUT = 250000,
  parameter band_arr_t LO_TABLE = BAND_LO,
  parameter band_arr_t HI_TABLE = BAND_HI
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              waveform,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              note_change,
  output logic [CNT_W-1:0]  period_out,
  output logic              no_signal,
  output logic              out_of_range
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(TIMEOUT);
  localparam logic [STABLE_W-1:0] STB_N =
    STABLE_W'(STABLE_N);
  localparam logic [STABLE_W-1:0] STB_MAX = '1;

  state_t state;
  state_t next_state;

  logic sync1;
  logic sync2;
  logic prev;
  logic rise;

  logic [CNT_W-1:0]    count;
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] idx;
  logic [CNT_W-1:0]    period;
  logic [ACC_W-1:0]    acc_sum;
  logic                counting;
  logic                timeout_hit;
  logic                win_strobe;

  logic              cls_valid;
  logic              cls_match;
  logic [NOTE_W-1:0] cls_code;

  logic [NOTE_W-1:0]   cand;
  logic [STABLE_W-1:0] stable;
  logic [STABLE_W-1:0] stable_nx;
  logic                valid_q;

  assign rise = sync2 & ~prev;

  assign counting =
    (state == ARM) || (state == MEASURE);

  // A rise in the same cycle beats the timeout.
  assign timeout_hit =
    counting && (count == TMO) && !rise;

  assign period = (count == CNT_MAX) ?
    CNT_MAX : count + CNT_W'(1);

  assign acc_sum = acc + ACC_W'(period);

  // Dropping enable hides the note at once.
  assign note_valid = valid_q & enable;

  // Synchronise the pin and keep a previous
  // sample for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= waveform;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    next_state = ARM;
        ARM:     if (rise) next_state = MEASURE;
        MEASURE: if (timeout_hit) next_state = ARM;
        default: next_state = IDLE;
      endcase
    end
  end

  // Period counter, accumulator and window close.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      acc        <= '0;
      idx        <= '0;
      period_out <= '0;
      win_strobe <= 1'b0;
    end else begin
      win_strobe <= 1'b0;
      if (!enable || state == IDLE) begin
        count <= '0;
        acc   <= '0;
        idx   <= '0;
      end else if (state == ARM) begin
        if (rise) begin
          count <= '0;
          acc   <= '0;
          idx   <= '0;
        end else if (timeout_hit) begin
          count <= '0;
        end else if (count != CNT_MAX) begin
          count <= count + CNT_W'(1);
        end
      end else if (state == MEASURE) begin
        if (rise) begin
          count <= '0;
          idx   <= idx + AVG_LOG2'(1);
          if (idx == '1) begin
            acc        <= '0;
            period_out <=
              CNT_W'(acc_sum >> AVG_LOG2);
            win_strobe <= 1'b1;
          end else begin
            acc <= acc_sum;
          end
        end else if (timeout_hit) begin
          count <= '0;
        end else if (count != CNT_MAX) begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

  note_band_lookup #(
    .CNT_W    (CNT_W),
    .NOTE_W   (NOTE_W),
    .LO_TABLE (LO_TABLE),
    .HI_TABLE (HI_TABLE)
  ) u_lookup (
    .clk    (clk),
    .reset  (reset),
    .strobe (win_strobe),
    .avg    (period_out),
    .valid  (cls_valid),
    .match  (cls_match),
    .code   (cls_code)
  );

  // Next stability count for a matched window.
  always_comb begin
    stable_nx = STABLE_W'(1);
    if (cls_code == cand) begin
      stable_nx = (stable == STB_MAX) ?
        STB_MAX : stable + STABLE_W'(1);
    end
  end

  // Stability filter, note publish, timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_out     <= '0;
      valid_q      <= 1'b0;
      note_change  <= 1'b0;
      no_signal    <= 1'b0;
      out_of_range <= 1'b0;
      cand         <= '0;
      stable       <= '0;
    end else begin
      note_change  <= 1'b0;
      out_of_range <= 1'b0;
      if (!enable) begin
        valid_q <= 1'b0;
      end else begin
        if (cls_valid) begin
          if (!cls_match) begin
            out_of_range <= 1'b1;
            stable       <= '0;
          end else begin
            cand   <= cls_code;
            stable <= stable_nx;
            if (stable_nx >= STB_N &&
                (!valid_q ||
                 cls_code != note_out)) begin
              note_out    <= cls_code;
              valid_q     <= 1'b1;
              note_change <= 1'b1;
            end
          end
        end
        if (rise && counting) begin
          no_signal <= 1'b0;
        end else if (timeout_hit) begin
          no_signal <= 1'b1;
          valid_q   <= 1'b0;
          stable    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_detector_avg.sv
// tb_note_detector_avg: directed scenarios on a
// scaled band table (cycles = spec values / 1000).
module tb_note_detector_avg;
  import note_detect_pkg::*;

  localparam int CNT_W = 24;
  localparam int NOTE_W = 3;
  localparam int TMO = 250;

  localparam band_arr_t TLO = {
    32'd190, 32'd170, 32'd150, 32'd135,
    32'd125, 32'd110, 32'd95,  32'd93
  };
  localparam band_arr_t THI = {
    32'd210, 32'd190, 32'd170, 32'd150,
    32'd135, 32'd125, 32'd110, 32'd95
  };

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic waveform;
  logic [NOTE_W-1:0] note_out;
  logic note_valid;
  logic note_change;
  logic [CNT_W-1:0] period_out;
  logic no_signal;
  logic out_of_range;

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int last = 0;
  int nc_cnt = 0;
  int oor_cnt = 0;
  int nc0;
  int oor0;

  note_detector_avg #(
    .CNT_W    (CNT_W),
    .NOTE_W   (NOTE_W),
    .AVG_LOG2 (2),
    .STABLE_N (2),
    .TIMEOUT  (TMO),
    .LO_TABLE (TLO),
    .HI_TABLE (THI)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .waveform     (waveform),
    .note_out     (note_out),
    .note_valid   (note_valid),
    .note_change  (note_change),
    .period_out   (period_out),
    .no_signal    (no_signal),
    .out_of_range (out_of_range)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_change) nc_cnt++;
    if (out_of_range) oor_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  // Pin rise exactly p cycles after the last one.
  task automatic rise_in(input int p);
    while (cyc - last < p) @(negedge clk);
    waveform = 1'b1;
    last = cyc;
    repeat (4) @(negedge clk);
    waveform = 1'b0;
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic chk(input string name,
                     input int got, input int exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    waveform = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst note_out", int'(note_out), 0);
    chk("rst note_valid", int'(note_valid), 0);
    chk("rst note_change", int'(note_change), 0);
    chk("rst period_out", int'(period_out), 0);
    chk("rst no_signal", int'(no_signal), 0);
    chk("rst out_of_range", int'(out_of_range), 0);
    reset = 1'b1;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_note();
    rise_in(200);
    for (int i = 0; i < 4; i++) rise_in(200);
    settle();
    chk("w1 period", int'(period_out), 200);
    chk("w1 valid", int'(note_valid), 0);
    for (int i = 0; i < 4; i++) rise_in(200);
    settle();
    chk("w2 period", int'(period_out), 200);
    chk("w2 note", int'(note_out), 0);
    chk("w2 valid", int'(note_valid), 1);
    chk("w2 changes", nc_cnt, 1);
    chk("w2 oor", oor_cnt, 0);
    chk("w2 no_signal", int'(no_signal), 0);
  endtask

  task automatic test_note_switch();
    nc0 = nc_cnt;
    for (int i = 0; i < 4; i++) rise_in(130);
    settle();
    chk("sw1 period", int'(period_out), 130);
    chk("sw1 note", int'(note_out), 0);
    chk("sw1 changes", nc_cnt, nc0);
    for (int i = 0; i < 4; i++) rise_in(130);
    settle();
    chk("sw2 note", int'(note_out), 4);
    chk("sw2 valid", int'(note_valid), 1);
    chk("sw2 changes", nc_cnt, nc0 + 1);
  endtask

  task automatic test_repeat();
    nc0 = nc_cnt;
    for (int i = 0; i < 4; i++) rise_in(130);
    settle();
    chk("rep note", int'(note_out), 4);
    chk("rep changes", nc_cnt, nc0);
  endtask

  task automatic test_out_of_range();
    nc0 = nc_cnt;
    oor0 = oor_cnt;
    for (int i = 0; i < 4; i++) rise_in(50);
    settle();
    chk("oor1 count", oor_cnt, oor0 + 1);
    chk("oor1 period", int'(period_out), 50);
    chk("oor1 note", int'(note_out), 4);
    chk("oor1 valid", int'(note_valid), 1);
    for (int i = 0; i < 4; i++) rise_in(50);
    settle();
    chk("oor2 count", oor_cnt, oor0 + 2);
    chk("oor2 changes", nc_cnt, nc0);
  endtask

  task automatic test_alternate();
    nc0 = nc_cnt;
    oor0 = oor_cnt;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 4; i++)
        rise_in((w % 2 == 0) ? 200 : 180);
      settle();
      chk("alt period", int'(period_out),
          (w % 2 == 0) ? 200 : 180);
      chk("alt note", int'(note_out), 4);
    end
    chk("alt changes", nc_cnt, nc0);
    chk("alt oor", oor_cnt, oor0);
  endtask

  task automatic test_timeout();
    while (cyc < last + TMO + 3) @(negedge clk);
    chk("tmo before ns", int'(no_signal), 0);
    chk("tmo before valid", int'(note_valid), 1);
    @(negedge clk);
    chk("tmo ns", int'(no_signal), 1);
    chk("tmo valid", int'(note_valid), 0);
    rise_in(300);
    settle();
    chk("tmo cleared", int'(no_signal), 0);
  endtask

  task automatic test_enable_drop();
    nc0 = nc_cnt;
    for (int i = 0; i < 8; i++) rise_in(200);
    settle();
    chk("en valid", int'(note_valid), 1);
    chk("en note", int'(note_out), 0);
    chk("en changes", nc_cnt, nc0 + 1);
    rise_in(200);
    rise_in(200);
    enable = 1'b0;
    #1;
    chk("en drop valid", int'(note_valid), 0);
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    rise_in(200);
    for (int i = 0; i < 4; i++) rise_in(200);
    settle();
    chk("rm pre valid", int'(note_valid), 1);
    rise_in(200);
    rise_in(200);
    reset = 1'b0;
    #1;
    chk("rm note_out", int'(note_out), 0);
    chk("rm valid", int'(note_valid), 0);
    chk("rm period", int'(period_out), 0);
    chk("rm ns", int'(no_signal), 0);
    @(negedge clk);
    reset = 1'b1;
    rise_in(200);
    for (int i = 0; i < 4; i++) rise_in(200);
    settle();
    chk("rm w1 period", int'(period_out), 200);
    chk("rm w1 valid", int'(note_valid), 0);
    for (int i = 0; i < 4; i++) rise_in(200);
    settle();
    chk("rm w2 valid", int'(note_valid), 1);
    chk("rm w2 note", int'(note_out), 0);
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    waveform = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_note();
    test_note_switch();
    test_repeat();
    test_out_of_range();
    test_alternate();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule

// File: doc/note_detector_avg.md
Name: note_detector_avg

Overview:
- Parametrised successor to the single-period note detector.
- Measures the period of a 1-bit tone waveform and averages it over 2^AVG_LOG2 periods.
- Classifies the average against a band table and publishes a note only after STABLE_N consecutive agreeing windows.
- Adds input synchronisation, a no-signal timeout, out-of-range flagging and a change pulse. Sits between the comparator front end and the display/scoring logic.

Parameters:
- CNT_W, 24, period counter / accumulator base width.
- NOTE_W, 3, note code width.
- AVG_LOG2, 2, log2 of periods averaged per window.
- STABLE_N, 2, consecutive identical classifications required to update the output; legal range 1..15.
- TIMEOUT, 250000, cycles without a rising edge before no_signal asserts; must be < 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  detector enable; low forces IDLE
- waveform  in  1  asynchronous tone input
- note_out  out  NOTE_W  current note code
- note_valid  out  1  note_out is meaningful
- note_change  out  1  one-cycle pulse when note_out/note_valid is updated to a new note
- period_out  out  CNT_W  last window average period, in cycles
- no_signal  out  1  level; timeout reached since last edge
- out_of_range  out  1  one-cycle pulse; window average matched no band

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, counter/accumulator/window index/stable count cleared.
- Input path: 2-flop synchroniser, then a previous-value flop. rise = sync & ~prev. Edge latency is 3 cycles from a pin transition; all timing below is referenced to rise.
- FSM IDLE: enable=1 -> ARM. Any state with enable=0 -> IDLE, and note_valid is cleared the same cycle.
- FSM ARM: wait for rise. On rise: count=0, acc=0, window index=0 -> MEASURE.
- FSM MEASURE: count increments every cycle, saturating at 2^CNT_W-1.
  - On rise: period = count+1, acc += period, count=0, index++.
  - When index wraps at 2^AVG_LOG2: avg = acc >> AVG_LOG2 is registered into period_out, acc clears, and the classify stage fires the next cycle. FSM stays in MEASURE, so no edge is lost.
- Accumulator width is CNT_W+AVG_LOG2; no overflow is possible.
- Timeout: count == TIMEOUT in ARM or MEASURE -> no_signal=1, note_valid=0, stable count=0 -> ARM. no_signal clears on the next rise.
- Classify stage, 1 cycle, sub-module:
  - Band i matches when LO[i] <= avg < HI[i]; lowest index wins.
  - No match: out_of_range pulse, stable count=0, outputs held.
- Stability:
  - Candidate equal to previous candidate: stable++ (saturating). Otherwise stable=1.
  - When stable >= STABLE_N and (!note_valid or candidate != note_out): note_out=candidate, note_valid=1, note_change pulse.
  - A repeated identical note produces no further pulse.
- Latency: note_out updates 2 cycles after the rise that closes the qualifying window.
- Simultaneous rise and timeout in the same cycle: rise wins and counts as a valid period.

Decomposition:
- note_detect_pkg holds:
  - state enum (IDLE/ARM/MEASURE);
  - NUM_NOTES=8;
  - band LO/HI constant arrays: Sa 190000-210000, Re 170000-190000, Ga 150000-170000, Ma 135000-150000, Pa 125000-135000, Dha 110000-125000, Ni 95000-110000, HighSa 93000-95000;
  - note codes 0..7.
- Sub-module note_band_lookup: registered avg -> {match, code}.

Test Plan:
- Reset pulled low mid-MEASURE with note_valid=1 -> all outputs 0 immediately. After release with enable=1, FSM is in ARM and the first rise starts measurement.
- Square wave, period 200000, AVG_LOG2=2, STABLE_N=2 -> after 8 full periods: period_out=200000, note_out=0, note_valid=1, exactly one note_change pulse.
- Steady at 200000, then switch to 130000 on a window boundary -> two windows later note_out=4 with one note_change; the intermediate window leaves note_out=0.
- Period 50000 -> out_of_range pulse after each window; note_out and note_valid unchanged.
- Waveform held low after the last rise -> exactly TIMEOUT=250000 cycles later no_signal=1 and note_valid=0. Next rise clears no_signal.
- Windows alternating between averages 200000 and 180000 -> candidate alternates and note_out never updates. Deassert enable mid-window -> note_valid=0 the same cycle.
